// File: rtl/lock_input_conditioner.sv
// lock_input_conditioner
//
// Front end for the electronic-lock controller. Brings the raw keypad
// pushbuttons and slide switches into the clk domain, debounces them and
// turns them into clean single-cycle events for the lock FSM.
//
// Ports
//   clk           in   board clock, all logic on the rising edge
//   rst           in   synchronous, active-high reset
//   pushbtns[3:0] in   raw asynchronous pushbuttons (bit i = display position i)
//   switches[5:0] in   raw asynchronous switches: [3:0] hex digit,
//                      [4] enter toggle, [5] relock toggle
//   btn_pulse     out  one-hot single-cycle strobe on a valid single press
//   btn_digit     out  debounced digit captured with btn_pulse, held between presses
//   digit         out  live debounced switches[3:0]
//   enter_pulse   out  single-cycle strobe on debounced switches[4] falling
//   relock_pulse  out  single-cycle strobe on debounced switches[5] falling
//   multi_press   out  single-cycle strobe when several buttons land together from IDLE
//   btn_level     out  debounced pushbutton levels
//   btn_fsm_state out  debug view of the button FSM (0 = IDLE, 1 = HELD)
//
// Handshake: there is no valid/ready pair. Every strobe is fire-and-forget
// and lasts exactly one cycle; the consumer must sample every cycle.
module lock_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] pushbtns,
  input  logic [5:0] switches,
  output logic [3:0] btn_pulse,
  output logic [3:0] btn_digit,
  output logic [3:0] digit,
  output logic       enter_pulse,
  output logic       relock_pulse,
  output logic       multi_press,
  output logic [3:0] btn_level,
  output logic       btn_fsm_state
);

  localparam int NBITS = 10;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HELD = 1'b1
  } btn_state_t;

  // Bit layout of the conditioned vector:
  //   [3:0] buttons, [7:4] digit switches, [8] enter, [9] relock
  logic [NBITS-1:0] w_raw;
  assign w_raw = {switches, pushbtns};

  logic [NBITS-1:0] r_sync1;
  logic [NBITS-1:0] r_sync2;
  logic [NBITS-1:0] r_stable;
  logic [CNT_W-1:0] r_cnt [NBITS];

  // Two-flop synchroniser for every raw bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Per-bit debouncer: the stable level only follows the synchronised
  // input after DEBOUNCE_CYCLES consecutive cycles of disagreement; any
  // return to agreement clears the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stable <= '0;
      for (int i = 0; i < NBITS; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NBITS; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_LIMIT) begin
          r_stable[i] <= r_sync2[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_ONE;
        end
      end
    end
  end

  // Falling-edge strobes for enter/relock. Only the two toggle bits need a
  // delayed copy; the other stable bits are never edge-detected.
  logic [1:0] r_dly;
  logic       r_enter_pulse;
  logic       r_relock_pulse;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dly          <= '0;
      r_enter_pulse  <= 1'b0;
      r_relock_pulse <= 1'b0;
    end else begin
      r_dly          <= r_stable[9:8];
      r_enter_pulse  <= r_dly[0] & ~r_stable[8];
      r_relock_pulse <= r_dly[1] & ~r_stable[9];
    end
  end

  // Button FSM: one event per press/release cycle. A press that lands on
  // several buttons at once reports multi_press instead of a digit store.
  logic [3:0] w_btn;
  logic       w_btn_any;
  logic       w_btn_onehot;
  btn_state_t r_state;
  btn_state_t w_state_next;
  logic [3:0] w_pulse_next;
  logic       w_multi_next;
  logic       w_capture;
  logic [3:0] r_btn_pulse;
  logic [3:0] r_btn_digit;
  logic       r_multi_press;

  assign w_btn        = r_stable[3:0];
  assign w_btn_any    = |w_btn;
  assign w_btn_onehot = w_btn_any && ((w_btn & (w_btn - 4'd1)) == 4'd0);

  always_comb begin
    w_state_next = r_state;
    w_pulse_next = 4'd0;
    w_multi_next = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_btn_any) begin
          if (w_btn_onehot) begin
            w_pulse_next = w_btn;
            w_capture    = 1'b1;
          end else begin
            w_multi_next = 1'b1;
          end
          w_state_next = ST_HELD;
        end
      end
      ST_HELD: begin
        // Extra buttons while held are ignored; wait for a full release.
        if (!w_btn_any) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_btn_pulse   <= 4'd0;
      r_btn_digit   <= 4'd0;
      r_multi_press <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_btn_pulse   <= w_pulse_next;
      r_multi_press <= w_multi_next;
      if (w_capture) begin
        r_btn_digit <= r_stable[7:4];
      end
    end
  end

  assign btn_pulse     = r_btn_pulse;
  assign btn_digit     = r_btn_digit;
  assign digit         = r_stable[7:4];
  assign enter_pulse   = r_enter_pulse;
  assign relock_pulse  = r_relock_pulse;
  assign multi_press   = r_multi_press;
  assign btn_level     = r_stable[3:0];
  assign btn_fsm_state = r_state;

endmodule

// File: tb/tb_lock_input_conditioner.sv
// Directed bench for lock_input_conditioner with DEBOUNCE_CYCLES=8.
// Each raw stimulus edge that must yield an event pushes the expected
// strobes, tagged with the cycle they must appear in, onto exp_q. A
// negedge monitor pops and compares on the due cycle and requires all
// strobes to be 0 on every other cycle.
module tb_lock_input_conditioner;

  localparam int DEB = 8;
  localparam int LAT = 2 + DEB + 1;

  logic       clk;
  logic       rst;
  logic [3:0] pushbtns;
  logic [5:0] switches;
  logic [3:0] btn_pulse;
  logic [3:0] btn_digit;
  logic [3:0] digit;
  logic       enter_pulse;
  logic       relock_pulse;
  logic       multi_press;
  logic [3:0] btn_level;
  logic       btn_fsm_state;

  lock_input_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pushbtns     (pushbtns),
    .switches     (switches),
    .btn_pulse    (btn_pulse),
    .btn_digit    (btn_digit),
    .digit        (digit),
    .enter_pulse  (enter_pulse),
    .relock_pulse (relock_pulse),
    .multi_press  (multi_press),
    .btn_level    (btn_level),
    .btn_fsm_state(btn_fsm_state)
  );

  // ---------------- clock / reset / cycle count ----------------
  initial clk = 1'b0;
  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  // entry: {due_cycle[15:0], btn_pulse[3:0], enter, relock, multi, btn_digit[3:0]}
  logic [26:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic expect_evt(input logic [3:0] btn, input logic ent, input logic rel,
                            input logic mul, input logic [3:0] dig);
    logic [15:0] due;
    due = 16'(cyc + LAT);
    exp_q.push_back({due, btn, ent, rel, mul, dig});
  endtask

  always @(negedge clk) begin
    logic [6:0]  obs;
    logic [26:0] e;
    obs = {btn_pulse, enter_pulse, relock_pulse, multi_press};
    if (exp_q.size() > 0 && exp_q[0][26:11] == 16'(cyc)) begin
      e = exp_q.pop_front();
      check("event_strobes", {1'b0, obs}, {1'b0, e[10:4]});
      check("event_btn_digit", {4'd0, btn_digit}, {4'd0, e[3:0]});
    end else begin
      check("quiet_strobes", {1'b0, obs}, 8'd0);
    end
  end

  // ---------------- driver ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {btn_digit, digit}, 8'd0);
    check(tag, {btn_level, 3'd0, btn_fsm_state}, 8'd0);
  endtask

  initial begin
    rst      = 1'b1;
    pushbtns = 4'd0;
    switches = 6'd0;
    tick(3);
    rst = 1'b0;
    tick(20);
    check_all_zero("reset_idle");

    // Single button press with digit 5
    switches = 6'h05;
    tick(12);
    check("digit_live_5", {4'd0, digit}, 8'h05);
    pushbtns = 4'b0001;
    expect_evt(4'b0001, 1'b0, 1'b0, 1'b0, 4'h5);
    tick(30);
    check("level_held", {4'd0, btn_level}, 8'h01);
    check("fsm_held", {7'd0, btn_fsm_state}, 8'h01);
    pushbtns = 4'b0000;
    tick(20);
    check("fsm_idle_after_release", {7'd0, btn_fsm_state}, 8'h00);

    // Reset 5 cycles into a debounce, released at the same time: nothing
    pushbtns = 4'b0001;
    tick(5);
    rst = 1'b1;
    tick(1);
    check_all_zero("reset_mid_count");
    rst      = 1'b0;
    pushbtns = 4'b0000;
    tick(20);

    // Reset mid-count with the button kept pressed: counts from scratch
    pushbtns = 4'b0001;
    tick(5);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    expect_evt(4'b0001, 1'b0, 1'b0, 1'b0, 4'h5);
    tick(25);
    pushbtns = 4'b0000;
    tick(20);

    // Bouncing button: 3-cycle segments never debounce
    for (int i = 0; i < 14; i++) begin
      pushbtns = (i % 2 == 0) ? 4'b0001 : 4'b0000;
      tick(3);
    end
    check("bounce_no_level", {4'd0, btn_level}, 8'h00);
    pushbtns = 4'b0001;
    expect_evt(4'b0001, 1'b0, 1'b0, 1'b0, 4'h5);
    tick(25);
    pushbtns = 4'b0000;
    tick(20);

    // Two buttons together -> multi_press; later additions ignored
    pushbtns = 4'b0110;
    expect_evt(4'b0000, 1'b0, 1'b0, 1'b1, 4'h5);
    tick(20);
    pushbtns = 4'b0010;
    tick(15);
    pushbtns = 4'b1010;
    tick(20);
    check("level_1010", {4'd0, btn_level}, 8'h0a);
    pushbtns = 4'b0000;
    tick(20);
    pushbtns = 4'b1000;
    expect_evt(4'b1000, 1'b0, 1'b0, 1'b0, 4'h5);
    tick(20);
    pushbtns = 4'b0000;
    tick(20);

    // Enter toggle: rise is silent, fall strobes
    switches = 6'h15;
    tick(20);
    switches = 6'h05;
    expect_evt(4'b0000, 1'b1, 1'b0, 1'b0, 4'h5);
    tick(20);

    // Relock toggle
    switches = 6'h25;
    tick(20);
    switches = 6'h05;
    expect_evt(4'b0000, 1'b0, 1'b1, 1'b0, 4'h5);
    tick(20);

    // Enter fall coincident with a button press
    switches = 6'h15;
    tick(20);
    switches = 6'h05;
    pushbtns = 4'b0100;
    expect_evt(4'b0100, 1'b1, 1'b0, 1'b0, 4'h5);
    tick(20);
    pushbtns = 4'b0000;
    tick(20);

    // New digit captured with the press
    switches = 6'h0a;
    tick(12);
    check("digit_live_a", {4'd0, digit}, 8'h0a);
    pushbtns = 4'b0001;
    expect_evt(4'b0001, 1'b0, 1'b0, 1'b0, 4'ha);
    tick(20);

    // Reset while held with a nonzero digit clears everything
    rst = 1'b1;
    tick(1);
    check_all_zero("reset_while_held");
    rst      = 1'b0;
    pushbtns = 4'b0000;
    switches = 6'h00;
    tick(20);

    check("queue_drained", 8'(exp_q.size()), 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
